// File: rtl/adder_meas_seq.sv
// adder_meas_seq: Wishbone-controlled measurement sequencer for the instrumented
// adder. Software loads A/B/PERIOD and writes start; the block applies the
// operands, waits for the adder to settle, gates the ring counter for PERIOD
// clocks, lets the ring domain quiesce and captures the count into RESULT.
//
// Optional build macro: ADDER_MEAS_CONTINUOUS_EN (CTRL.cont repeats rounds).
//
// Ports:
//   wb_clk_i, wb_rst_ni            clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i     Wishbone slave request (sel ignored)
//   wbs_adr_i, wbs_dat_i           address / write data
//   wbs_ack_o, wbs_dat_o           single-cycle ack / read data
//   adder_a, adder_b               operands driven to the adder
//   ring_en, cnt_clr, cnt_en       ring oscillator enable, counter clear, gate
//   ring_count                     ring counter value
//   busy                           sequence in progress
//
// Register map (offset): 0x00 CTRL (bit0 start, bit1 cont), 0x04 A, 0x08 B,
// 0x0C PERIOD, 0x10 RESULT (RO), 0x14 STATUS (RO: bit0 busy, bit1 done).
module adder_meas_seq #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned ADDER_W    = 32,
  parameter int unsigned COUNT_W    = 32,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned SYNC_CYC   = 3
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [ADDER_W-1:0] adder_a,
  output logic [ADDER_W-1:0] adder_b,
  output logic               ring_en,
  output logic               cnt_clr,
  output logic               cnt_en,
  input  logic [COUNT_W-1:0] ring_count,
  output logic               busy
);

  localparam logic [31:0] LAST_OFF = 32'h14;

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, RUN, STOP, CAPTURE
  } state_t;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] cyc_q, cyc_d;
  logic [ADDER_W-1:0] a_q, b_q;
  logic [COUNT_W-1:0] period_q, result_q;
  logic               done_q;
  logic               cont;
  logic [31:0]        rdata;

  // Address decode: word-aligned offsets 0x00..0x14 from BASE_ADDR
  logic [31:0] off;
  logic        hit, req, wr, rd;
  logic [2:0]  idx;
  logic        unused_sel;

  assign unused_sel = ^wbs_sel_i;
  assign off        = wbs_adr_i - BASE_ADDR;
  assign hit        = (off <= LAST_OFF) && (off[1:0] == 2'b00);
  assign idx        = off[4:2];
  // Suppress a new request in the ack cycle so acks never come back-to-back
  assign req        = wbs_stb_i & wbs_cyc_i & hit & ~wbs_ack_o;
  assign wr         = req & wbs_we_i;
  assign rd         = req & ~wbs_we_i;

  logic idle, start_wr, rd_status;
  assign idle      = (state_q == IDLE);
  assign start_wr  = wr && (idx == 3'd0) && wbs_dat_i[0];
  assign rd_status = rd && (idx == 3'd5);

  // Software registers; operand/period writes are dropped while sequencing
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      a_q      <= '0;
      b_q      <= '0;
      period_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      if (wr && idle && idx == 3'd1) a_q      <= ADDER_W'(wbs_dat_i);
      if (wr && idle && idx == 3'd2) b_q      <= ADDER_W'(wbs_dat_i);
      if (wr && idle && idx == 3'd3) period_q <= COUNT_W'(wbs_dat_i);
      if (state_q == CAPTURE) result_q <= ring_count;
      // A capture in the same cycle as a STATUS read keeps done set
      if (state_q == CAPTURE) done_q <= 1'b1;
      else if (rd_status)     done_q <= 1'b0;
    end
  end

`ifdef ADDER_MEAS_CONTINUOUS_EN
  // cont stays writable while busy so software can end a continuous run
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)               cont <= 1'b0;
    else if (wr && idx == 3'd0)   cont <= wbs_dat_i[1];
  end
`else
  assign cont = 1'b0;
`endif

  // Read mux
  always_comb begin
    rdata = '0;
    case (idx)
      3'd0:    rdata = {30'd0, cont, 1'b0};
      3'd1:    rdata = 32'(a_q);
      3'd2:    rdata = 32'(b_q);
      3'd3:    rdata = 32'(period_q);
      3'd4:    rdata = 32'(result_q);
      3'd5:    rdata = {30'd0, done_q, busy};
      default: rdata = '0;
    endcase
  end

  // Next-state logic; cyc_q counts down the remaining clocks of timed states
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    case (state_q)
      IDLE: begin
        if (start_wr) state_d = LOAD;
      end
      LOAD: begin
        state_d = SETTLE;
        cyc_d   = COUNT_W'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        if (cyc_q == '0) begin
          state_d = RUN;
          // PERIOD=0 still opens the gate for one clock
          cyc_d   = (period_q == '0) ? '0 : period_q - COUNT_W'(1);
        end else begin
          cyc_d = cyc_q - COUNT_W'(1);
        end
      end
      RUN: begin
        if (cyc_q == '0) begin
          state_d = STOP;
          cyc_d   = COUNT_W'(SYNC_CYC - 1);
        end else begin
          cyc_d = cyc_q - COUNT_W'(1);
        end
      end
      STOP: begin
        if (cyc_q == '0) state_d = CAPTURE;
        else             cyc_d   = cyc_q - COUNT_W'(1);
      end
      CAPTURE: begin
        state_d = cont ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered outputs decoded from the next state
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      adder_a   <= '0;
      adder_b   <= '0;
      ring_en   <= 1'b0;
      cnt_clr   <= 1'b0;
      cnt_en    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : '0;
      cnt_clr   <= (state_d == LOAD);
      ring_en   <= (state_d == LOAD) || (state_d == SETTLE) || (state_d == RUN);
      cnt_en    <= (state_d == RUN);
      busy      <= (state_d != IDLE);
      if (state_d == LOAD) begin
        adder_a <= a_q;
        adder_b <= b_q;
      end
    end
  end

endmodule
